// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver with a go/dr byte handshake.
// The rx line is synchronised, the start bit is confirmed at mid-bit, and
// each data bit and the stop bit are sampled at mid-bit (LSB first).
// frame_err and overrun are single-cycle pulses.
module uart_rx_sampler #(
  parameter int CLK_FREQ  = 20_250_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       go,
  output logic [7:0] data,
  output logic       dr,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BIT_TIME) + 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_TIME / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             rx_meta_q;
  logic             rxs_q;
  logic             rxs_prev_q;
  logic             ovr_seen_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_ix_q;
  logic [7:0]       data_q;
  logic             dr_q;
  logic             fe_q;
  logic             ovr_q;

  logic             rxs_fall;

  // Falling edge of the synchronised line, used only while a byte is held.
  assign rxs_fall = rxs_prev_q & ~rxs_q;

  assign data      = data_q;
  assign dr        = dr_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receive FSM with registered outputs; error pulses clear every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rxs_prev_q <= 1'b1;
      ovr_seen_q <= 1'b0;
      bit_cnt_q  <= '0;
      bit_ix_q   <= '0;
      data_q     <= '0;
      dr_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      rxs_prev_q <= rxs_q;

      case (state_q)
        S_IDLE: begin
          if (go && !rxs_q) begin
            state_q   <= S_START;
            bit_cnt_q <= '0;
          end
        end

        S_START: begin
          if (bit_cnt_q == HALF_M1) begin
            if (!rxs_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
              bit_ix_q  <= '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end

        S_DATA: begin
          if (bit_cnt_q == FULL_M1) begin
            data_q    <= {rxs_q, data_q[7:1]};
            bit_cnt_q <= '0;
            if (bit_ix_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_ix_q <= bit_ix_q + 3'd1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end

        S_STOP: begin
          if (bit_cnt_q == FULL_M1) begin
            bit_cnt_q <= '0;
            if (rxs_q) begin
              state_q    <= S_DONE;
              dr_q       <= 1'b1;
              ovr_seen_q <= 1'b0;
            end else begin
              state_q <= S_BREAK;
              fe_q    <= 1'b1;
              data_q  <= '0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end

        S_BREAK: begin
          // Hold off until the line returns high so a break is not a start.
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end

        S_DONE: begin
          if (!go) begin
            dr_q    <= 1'b0;
            state_q <= S_IDLE;
          end else if (rxs_fall && !ovr_seen_q) begin
            // Report only the first start edge; the line is ignored until ack.
            ovr_q      <= 1'b1;
            ovr_seen_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at BIT_TIME = 10 clocks.
module tb_uart_rx_sampler;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int BT        = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       go;
  logic [7:0] data;
  logic       dr;
  logic       frame_err;
  logic       overrun;

  uart_rx_sampler #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .go       (go),
    .data     (data),
    .dr       (dr),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Event monitor: counts dr rises, pulses, and back-to-back pulse cycles.
  int         dr_rises   = 0;
  int         fe_pulses  = 0;
  int         ovr_pulses = 0;
  int         fe_double  = 0;
  int         ovr_double = 0;
  int         dr_cyc     = 0;
  logic       dr_prev    = 1'b0;
  logic       fe_prev    = 1'b0;
  logic       ovr_prev   = 1'b0;
  logic [7:0] cap_q[$];

  always @(negedge clk) begin
    if (dr && !dr_prev) begin
      dr_rises = dr_rises + 1;
      dr_cyc   = cyc;
      cap_q.push_back(data);
    end
    if (frame_err) fe_pulses = fe_pulses + 1;
    if (frame_err && fe_prev) fe_double = fe_double + 1;
    if (overrun) ovr_pulses = ovr_pulses + 1;
    if (overrun && ovr_prev) ovr_double = ovr_double + 1;
    dr_prev  = dr;
    fe_prev  = frame_err;
    ovr_prev = overrun;
  end

  int n_total = 0;
  int n_pass  = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one 8N1 frame; the stop level may be forced low and then held low.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    @(posedge clk);
    #1 rx = 1'b0;
    start_cyc = cyc;
    repeat (BT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BT) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BT) @(posedge clk);
    if (hold_low > 0) repeat (hold_low) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic wait_dr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge: drop go for exactly one clock, then expect dr low.
  task automatic do_ack(input string name);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    check(name, dr, 1'b0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         hold_low;
    logic       exp_dr;
    logic       exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    bit ok2;
    int r0;
    int f0;
    int o0;
    int c0;
    int lat;
    logic [7:0] last_exp;

    vecs[0] = '{b: 8'hA5, stop: 1'b1, hold_low: 0,  exp_dr: 1'b1, exp_fe: 1'b0, exp_data: 8'hA5};
    vecs[1] = '{b: 8'h00, stop: 1'b1, hold_low: 0,  exp_dr: 1'b1, exp_fe: 1'b0, exp_data: 8'h00};
    vecs[2] = '{b: 8'hFF, stop: 1'b1, hold_low: 0,  exp_dr: 1'b1, exp_fe: 1'b0, exp_data: 8'hFF};
    vecs[3] = '{b: 8'h3C, stop: 1'b0, hold_low: 50, exp_dr: 1'b0, exp_fe: 1'b1, exp_data: 8'h00};
    vecs[4] = '{b: 8'h12, stop: 1'b1, hold_low: 0,  exp_dr: 1'b1, exp_fe: 1'b0, exp_data: 8'h12};
    vecs[5] = '{b: 8'h81, stop: 1'b1, hold_low: 0,  exp_dr: 1'b1, exp_fe: 1'b0, exp_data: 8'h81};

    rst_n = 1'b0;
    rx    = 1'b1;
    go    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_dr", dr, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table of single frames, each acknowledged before the next.
    last_exp = 8'h00;
    for (int v = 0; v < 6; v++) begin
      r0 = dr_rises;
      f0 = fe_pulses;
      send_frame(vecs[v].b, vecs[v].stop, vecs[v].hold_low);
      if (vecs[v].exp_dr) begin
        wait_dr(ok);
        check($sformatf("vec%0d_dr_seen", v), ok, 1'b1);
        check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
        lat = dr_cyc - start_cyc;
        if (!(lat >= 97 && lat <= 99)) $display("vec%0d latency was %0d cycles", v, lat);
        check($sformatf("vec%0d_latency_97_99", v), (lat >= 97 && lat <= 99), 1'b1);
        do_ack($sformatf("vec%0d_dr_low_after_ack", v));
      end else begin
        repeat (20) @(negedge clk);
        check($sformatf("vec%0d_dr_low", v), dr, 1'b0);
        check($sformatf("vec%0d_data_cleared", v), data, vecs[v].exp_data);
      end
      check($sformatf("vec%0d_dr_rises", v), dr_rises - r0, vecs[v].exp_dr);
      check($sformatf("vec%0d_fe_pulses", v), fe_pulses - f0, vecs[v].exp_fe);
      last_exp = vecs[v].exp_data;
    end

    // Short low glitch while idle: no byte, no error, data untouched.
    r0 = dr_rises;
    f0 = fe_pulses;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_dr", dr_rises - r0, 0);
    check("glitch_no_fe", fe_pulses - f0, 0);
    check("glitch_data", data, last_exp);

    // Back-to-back 0x00 then 0xFF, acknowledged concurrently.
    r0 = dr_rises;
    o0 = ovr_pulses;
    c0 = cap_q.size();
    fork
      begin
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
      end
      begin
        wait_dr(ok);
        check("b2b_first_dr_seen", ok, 1'b1);
        do_ack("b2b_first_ack");
        wait_dr(ok2);
        check("b2b_second_dr_seen", ok2, 1'b1);
        do_ack("b2b_second_ack");
      end
    join
    repeat (5) @(negedge clk);
    check("b2b_dr_rises", dr_rises - r0, 2);
    check("b2b_no_overrun", ovr_pulses - o0, 0);
    if (cap_q.size() >= c0 + 2) begin
      check("b2b_data0", cap_q[c0], 8'h00);
      check("b2b_data1", cap_q[c0 + 1], 8'hFF);
    end else begin
      check("b2b_capture_count", cap_q.size() - c0, 2);
    end

    // Withheld ack: second frame triggers a single overrun pulse.
    send_frame(8'h41, 1'b1, 0);
    wait_dr(ok);
    check("ovr_first_dr_seen", ok, 1'b1);
    check("ovr_first_data", data, 8'h41);
    o0 = ovr_pulses;
    send_frame(8'h42, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("ovr_pulse_count", ovr_pulses - o0, 1);
    check("ovr_dr_held", dr, 1'b1);
    check("ovr_data_held", data, 8'h41);
    do_ack("ovr_ack");
    r0 = dr_rises;
    repeat (150) @(negedge clk);
    check("ovr_no_late_byte", dr_rises - r0, 0);

    // go low in idle: start bits are ignored.
    @(negedge clk);
    go = 1'b0;
    r0 = dr_rises;
    send_frame(8'h55, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("go_low_ignored", dr_rises - r0, 0);
    go = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame, held until the line is idle again.
    r0 = dr_rises;
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        @(posedge clk);
        repeat (55) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_data", data, 8'h00);
        check("midreset_dr", dr, 1'b0);
        check("midreset_fe", frame_err, 1'b0);
        check("midreset_ovr", overrun, 1'b0);
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_byte", dr_rises - r0, 0);
    send_frame(8'h7E, 1'b1, 0);
    wait_dr(ok);
    check("post_reset_dr_seen", ok, 1'b1);
    check("post_reset_data", data, 8'h7E);
    do_ack("post_reset_ack");

    check("fe_never_two_cycles", fe_double, 0);
    check("ovr_never_two_cycles", ovr_double, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
